// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, fetch FSM
// state encoding, reset PC and the PC increment helper.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Wraps modulo 2^32; the low two bits are carried through untouched.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_redirect_sel.sv
// Priority selection of the redirect target coming from the decode stage:
// JR wins over J, which wins over a taken branch.
module if_redirect_sel (
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic        redirect,
  output logic [31:0] target
);

  // Priority mux over the three redirect sources
  always_comb begin
    redirect = Z | J | JR;
    if (JR) begin
      target = JrAddr;
    end else if (J) begin
      target = JumpAddr;
    end else if (Z) begin
      target = BranchAddr;
    end else begin
      target = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM over a req/ack instruction memory,
// one-word stall buffer, pending redirect target and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_IFWrite,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  buf_r, buf_nxt_s;
  logic [31:0]  tgt_r, tgt_nxt_s;
  logic [31:0]  instr_nxt_s, npc_nxt_s;
  logic         req_s;
  logic         redirect_s;
  logic [31:0]  target_s;

  if_redirect_sel u_redirect_sel (
    .Z          (Z),
    .J          (J),
    .JR         (JR),
    .BranchAddr (BranchAddr),
    .JumpAddr   (JumpAddr),
    .JrAddr     (JrAddr),
    .redirect   (redirect_s),
    .target     (target_s)
  );

  // Fetch FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a DRAIN ack under stall stays in DRAIN and re-requests
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (!PC_IFWrite) begin
          state_nxt_s = imem_ack ? ST_HOLD : ST_FETCH;
        end else if (redirect_s && !imem_ack) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD:  state_nxt_s = PC_IFWrite ? ST_FETCH : ST_HOLD;
      ST_DRAIN: state_nxt_s = (PC_IFWrite && imem_ack) ? ST_FETCH : ST_DRAIN;
      default:  state_nxt_s = ST_FETCH;
    endcase
  end

  // Request and datapath next values; a stall holds pc and IF/ID everywhere
  always_comb begin
    req_s       = 1'b0;
    pc_nxt_s    = pc_r;
    buf_nxt_s   = buf_r;
    tgt_nxt_s   = tgt_r;
    instr_nxt_s = Instruction_id;
    npc_nxt_s   = NextPC_id;
    case (state_r)
      ST_FETCH: begin
        req_s = 1'b1;
        if (!PC_IFWrite) begin
          buf_nxt_s = imem_ack ? imem_rdata : buf_r;
        end else if (redirect_s) begin
          instr_nxt_s = NOP;
          if (imem_ack) begin
            pc_nxt_s = target_s;
          end else begin
            tgt_nxt_s = target_s;
          end
        end else if (imem_ack) begin
          instr_nxt_s = imem_rdata;
          npc_nxt_s   = pc_plus4(pc_r);
          pc_nxt_s    = pc_plus4(pc_r);
        end else begin
          instr_nxt_s = NOP;
        end
      end
      ST_HOLD: begin
        if (!PC_IFWrite) begin
          pc_nxt_s = pc_r;
        end else if (redirect_s) begin
          instr_nxt_s = NOP;
          pc_nxt_s    = target_s;
        end else begin
          instr_nxt_s = buf_r;
          npc_nxt_s   = pc_plus4(pc_r);
          pc_nxt_s    = pc_plus4(pc_r);
        end
      end
      ST_DRAIN: begin
        req_s = 1'b1;
        if (PC_IFWrite) begin
          instr_nxt_s = NOP;
          pc_nxt_s    = imem_ack ? tgt_r : pc_r;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_s & ~reset;
  assign imem_addr = pc_r;

  // PC, stall buffer, redirect target and IF/ID registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r           <= RESET_PC;
      buf_r          <= 32'h0000_0000;
      tgt_r          <= 32'h0000_0000;
      Instruction_id <= NOP;
      NextPC_id      <= 32'h0000_0000;
    end else begin
      pc_r           <= pc_nxt_s;
      buf_r          <= buf_nxt_s;
      tgt_r          <= tgt_nxt_s;
      Instruction_id <= instr_nxt_s;
      NextPC_id      <= npc_nxt_s;
    end
  end

endmodule
